// File: rtl/id_stage_hazard_pipe.sv
// MIPS ID stage: decode, register file, EX/MEM/WB forwarding, in-ID branch/jump, load-use stall FSM, ID/EX register.
// Define IDSTAGE_FWD_EX_EN to enable forwarding from EX; otherwise any EX write dependency stalls one cycle.
module id_stage_hazard_pipe #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int LOAD_LAT = 1,
  localparam int RW      = $clog2(NREGS)
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            InValid,
  input  logic [31:0]     Inst,
  input  logic            EXRegWrite,
  input  logic            EXMemRead,
  input  logic [RW-1:0]   EXRd,
  input  logic [XLEN-1:0] EXData,
  input  logic            MEMRegWrite,
  input  logic [RW-1:0]   MEMRd,
  input  logic [XLEN-1:0] MEMData,
  input  logic            WBRegWrite,
  input  logic [RW-1:0]   WBRd,
  input  logic [XLEN-1:0] WBData,
  output logic            Stall,
  output logic            Branch,
  output logic            Jump,
  output logic [XLEN-1:0] BranchOffset,
  output logic [25:0]     JumpAddress,
  output logic            OutValid,
  output logic            ALUSrc,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic [2:0]      ALUControl,
  output logic [XLEN-1:0] DataA,
  output logic [XLEN-1:0] DataB,
  output logic [XLEN-1:0] SignExtend,
  output logic [RW-1:0]   Rs,
  output logic [RW-1:0]   Rt,
  output logic [RW-1:0]   Rd
);

  typedef enum logic {RUN, STALL} state_t;

  state_t          state;
  logic [1:0]      Cnt;
  logic            resume;
  logic [XLEN-1:0] rf [NREGS];

  logic [5:0]      opcode, funct;
  logic [RW-1:0]   rs, rt, rdf;
  logic [XLEN-1:0] imm_ext, src_a, src_b;

  logic            dec_ok, d_alusrc, d_memrd, d_memwr, d_regwr;
  logic [2:0]      d_aluctl;
  logic [RW-1:0]   d_rd;
  logic            use_rs, use_rt, is_beq, is_bne, is_j;
  logic            ex_fwd, ex_haz_kind, hazard;

  assign opcode  = Inst[31:26];
  assign funct   = Inst[5:0];
  assign rs      = Inst[21 +: RW];
  assign rt      = Inst[16 +: RW];
  assign rdf     = Inst[11 +: RW];
  assign imm_ext = XLEN'($signed(Inst[15:0]));

  assign BranchOffset = imm_ext << 2;
  assign JumpAddress  = Inst[25:0];

  // Load/store use the ALU add for address generation.
  always_comb begin
    dec_ok = 1'b0; d_alusrc = 1'b0; d_memrd = 1'b0; d_memwr = 1'b0; d_regwr = 1'b0;
    d_aluctl = '0; d_rd = '0; use_rs = 1'b0; use_rt = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0;
    case (opcode)
      6'h00: begin
        dec_ok = 1'b1;
        case (funct)
          6'h20:   d_aluctl = 3'b010;
          6'h22:   d_aluctl = 3'b110;
          6'h24:   d_aluctl = 3'b000;
          6'h25:   d_aluctl = 3'b001;
          6'h2A:   d_aluctl = 3'b111;
          default: dec_ok = 1'b0;
        endcase
        d_regwr = dec_ok;
        d_rd    = dec_ok ? rdf : '0;
        use_rs  = dec_ok;
        use_rt  = dec_ok;
      end
      6'h08: begin
        dec_ok = 1'b1; d_aluctl = 3'b010; d_alusrc = 1'b1; d_regwr = 1'b1; d_rd = rt; use_rs = 1'b1;
      end
      6'h23: begin
        dec_ok = 1'b1; d_aluctl = 3'b010; d_alusrc = 1'b1; d_memrd = 1'b1; d_regwr = 1'b1;
        d_rd = rt; use_rs = 1'b1;
      end
      6'h2B: begin
        dec_ok = 1'b1; d_aluctl = 3'b010; d_alusrc = 1'b1; d_memwr = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      6'h04: begin dec_ok = 1'b1; is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'h05: begin dec_ok = 1'b1; is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'h02: begin dec_ok = 1'b1; is_j = 1'b1; end
      default: ;
    endcase
  end

`ifdef IDSTAGE_FWD_EX_EN
  localparam bit MULTI = (LOAD_LAT > 1);
  assign ex_fwd      = EXRegWrite && !EXMemRead && !resume;
  assign ex_haz_kind = EXMemRead;
`else
  localparam bit MULTI = 1'b0;
  logic unused_ex;
  assign ex_fwd      = 1'b0;
  assign ex_haz_kind = 1'b1;
  assign unused_ex   = EXMemRead ^ (^EXData);
`endif

  function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] r);
    if (ex_fwd && EXRd != '0 && EXRd == r)             return EXData;
    if (MEMRegWrite && MEMRd != '0 && MEMRd == r)     return MEMData;
    if (WBRegWrite && WBRd != '0 && WBRd == r)        return WBData;
    return rf[r];
  endfunction

  always_comb begin
    src_a = fwd(rs);
    src_b = fwd(rt);
  end

  // The instruction released after a stall skips the EX check: its producer has moved past EX.
  assign hazard = (state == RUN) && !resume && InValid && EXRegWrite && ex_haz_kind &&
                  (EXRd != '0) && ((use_rs && EXRd == rs) || (use_rt && EXRd == rt));
  assign Stall  = Rst_n && ((state == STALL) || hazard);
  assign Branch = InValid && !Stall && ((is_beq && src_a == src_b) || (is_bne && src_a != src_b));
  assign Jump   = InValid && !Stall && is_j;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= RUN;
      Cnt    <= '0;
      resume <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            Cnt    <= MULTI ? 2'(LOAD_LAT - 1) : 2'd0;
            state  <= MULTI ? STALL : RUN;
            resume <= !MULTI;
          end else begin
            resume <= 1'b0;
          end
        end
        STALL: begin
          Cnt <= Cnt - 2'd1;
          if (Cnt <= 2'd1) begin
            state  <= RUN;
            resume <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (WBRegWrite && WBRd != '0) begin
      rf[WBRd] <= WBData;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      OutValid <= 1'b0; ALUSrc <= 1'b0; MemRead <= 1'b0; MemWrite <= 1'b0; RegWrite <= 1'b0;
      ALUControl <= '0; DataA <= '0; DataB <= '0; SignExtend <= '0;
      Rs <= '0; Rt <= '0; Rd <= '0;
    end else if (InValid && dec_ok && !Stall) begin
      OutValid   <= 1'b1;
      ALUSrc     <= d_alusrc;
      MemRead    <= d_memrd;
      MemWrite   <= d_memwr;
      RegWrite   <= d_regwr;
      ALUControl <= d_aluctl;
      DataA      <= src_a;
      DataB      <= src_b;
      SignExtend <= imm_ext;
      Rs         <= rs;
      Rt         <= rt;
      Rd         <= d_rd;
    end else begin
      OutValid   <= 1'b0;
      ALUSrc     <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      RegWrite   <= 1'b0;
      ALUControl <= '0;
    end
  end

endmodule

// File: doc/id_stage_hazard_pipe.md
Name: id_stage_hazard_pipe

Overview:
- Parametrised successor to the combinational ID stage of the 5-stage MIPS pipeline.
- Decodes, reads a built-in register file, forwards from EX/MEM/WB, resolves branches/jumps in ID.
- Inserts a configurable-length load-use stall via a small FSM; drives a registered ID/EX pipeline register with a valid bit.

Parameters:
- XLEN, 32, datapath width (≥16); SignExtend is imm16 sign-extended to XLEN.
- NREGS, 32, register count (power of 2, 8..32); RW = $clog2(NREGS) register-index bits.
- LOAD_LAT, 1, load-use bubbles inserted (1..3).

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  synchronous active-low reset
- InValid  in  1  Inst holds a real instruction
- Inst  in  32  MIPS instruction word
- EXRegWrite, EXMemRead  in  1 each  EX-stage control
- EXRd  in  RW  EX destination
- EXData  in  XLEN  EX ALU result
- MEMRegWrite  in  1; MEMRd  in  RW; MEMData  in  XLEN
- WBRegWrite  in  1; WBRd  in  RW; WBData  in  XLEN
- Stall  out  1  upstream must hold PC/Inst (combinational)
- Branch, Jump  out  1 each  taken beq/bne, j (combinational)
- BranchOffset  out  XLEN  SignExtend<<2
- JumpAddress  out  26  Inst[25:0]
- OutValid  out  1  ID/EX register holds a real instruction
- ALUSrc, MemRead, MemWrite, RegWrite  out  1 each  (registered)
- ALUControl  out  3  (registered)
- DataA, DataB, SignExtend  out  XLEN  (registered)
- Rs, Rt, Rd  out  RW  (registered; Rd = write destination)

Behaviour:
- Decode: R-type funct add/sub/and/or/slt → ALUControl 010/110/000/001/111, RegWrite=1, Rd=Inst[15:11]. addi(08) → ALU 010, ALUSrc=1, Rd=rt. lw(23) → MemRead, RegWrite, ALUSrc, Rd=rt. sw(2B) → MemWrite, ALUSrc. beq(04)/bne(05)/j(02) → no write, no mem. Unknown opcode → all controls 0, OutValid=0.
- Register indices use low RW bits of instruction fields.
- Register file: NREGS×XLEN. Reg 0 reads 0; writes to 0 ignored. Write at Clk edge when WBRegWrite. Same-cycle read of WBRd returns WBData.
- Forwarding per source, priority high→low, each only when RegWrite and Rd≠0 and Rd matches:
  - EX (only if not EXMemRead, EXData)
  - MEM (MEMData)
  - WB (WBData)
  - regfile
- FSM states RUN, STALL; 2-bit counter Cnt.
  - RUN: InValid, opcode reads rs (or rt for R/beq/bne/sw), EXMemRead, EXRegWrite, EXRd≠0 and EXRd matches → Stall=1 this cycle, Cnt←LOAD_LAT-1. Go STALL if LOAD_LAT>1, else stay RUN.
  - STALL: Stall=1, Cnt decrements. Return to RUN after cycle with Cnt=0; the instruction then proceeds with MEM/WB forwarding.
  - Stall: Branch/Jump forced 0; ID/EX loads bubble (OutValid=0, all controls 0, data don't-care but held).
- Branch = InValid & ~Stall & (beq ? A==B : bne ? A!=B : 0) using forwarded values. Jump = InValid & ~Stall & opcode j.
- ID/EX register updates every edge. InValid=0 → bubble.
- Reset (Rst_n=0 at edge, including mid-stall): all regfile entries 0, FSM RUN, Cnt 0, all registered outputs 0. Stall is gated by Rst_n.

Optional Feature:
- IDSTAGE_FWD_EX_EN.
- Defined: EX forwarding as above.
- Undefined: EX is never forwarded. Any EX-RegWrite dependency (load or not) stalls exactly 1 cycle, using the same FSM path with count 1.

Test Plan:
- Reset, then add $3,$1,$2 with WB writing $1=5 same cycle, $2=7 in regfile → next edge: DataA=5, DataB=7, ALUControl=010, Rd=3, OutValid=1.
- EX writes $1=0x11, MEM $1=0x22, WB $1=0x33; add $4,$1,$1 → DataA=DataB=0x11 (FWD_EX_EN), else Stall 1 cycle then 0x22.
- LOAD_LAT=2; EX lw→$1 held; add $1,$1,$1 → Stall high 2 cycles, two bubbles (OutValid=0), then instruction issues.
- beq $2,$3 with both 0x5 via MEM/regfile, imm 0xFFFF → Branch=1, BranchOffset=0xFFFFFFFC. bne same → Branch=0.
- j 0x000001 → Jump=1, JumpAddress=0x0000001. Same instruction during load-use stall → Jump=0.
- Assert Rst_n=0 during STALL → next edge: Stall=0, OutValid=0, regfile reads 0.
